// File: rtl/bcd_pkg.sv
// Shared types, display limits and digit-split helpers for the two-digit BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_MAX_DIGIT = 9;
  localparam int DISP_MAX_VAL  = 29;

  function automatic int tens_of(input int value);
    return value / 10;
  endfunction

  function automatic int ones_of(input int value);
    return value % 10;
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Control inputs and digit/pulse outputs of bcd_counter, bundled for port connection.
interface bcd_counter_if;
  import bcd_pkg::*;

  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  bcd_digit_t load_l;
  bcd_digit_t load_h;
  bcd_digit_t bcd_l;
  bcd_digit_t bcd_h;
  logic       tick;
  logic       wrap;
  logic       load_err;

  modport master (
    output en, up, clr, load, load_l, load_h,
    input  bcd_l, bcd_h, tick, wrap, load_err
  );

  modport slave (
    input  en, up, clr, load, load_l, load_h,
    output bcd_l, bcd_h, tick, wrap, load_err
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle whose edge completes a period.
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_rst,
  output logic step
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;

  assign step = en && (div_cnt_reg == LAST);

  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (sync_rst) begin
      div_cnt_next = '0;
    end else if (en) begin
      div_cnt_next = step ? '0 : div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Two-digit BCD up/down counter with prescaler, programmable wrap point,
// synchronous clear and range-checked parallel load.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int MAX_VAL = 23
) (
  input logic          clk,
  input logic          rst_n,
  bcd_counter_if.slave bus
);

  localparam bcd_digit_t MAX_H = bcd_digit_t'(tens_of(MAX_VAL));
  localparam bcd_digit_t MAX_L = bcd_digit_t'(ones_of(MAX_VAL));

  if (MAX_VAL < 1 || MAX_VAL > DISP_MAX_VAL) begin : g_bad_max_val
    $error("bcd_counter: MAX_VAL %0d outside 1..%0d", MAX_VAL, DISP_MAX_VAL);
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("bcd_counter: CLK_DIV %0d must be at least 1", CLK_DIV);
  end

  bcd_digit_t bcd_l_reg, bcd_l_next;
  bcd_digit_t bcd_h_reg, bcd_h_next;
  logic       tick_reg, tick_next;
  logic       wrap_reg, wrap_next;
  logic       load_err_reg, load_err_next;

  logic [7:0] load_sum;
  logic       load_ok;
  logic       load_rej;
  logic       step;
  logic       at_max;
  logic       at_zero;

  assign load_sum = ({4'd0, bus.load_h} * 8'd10) + {4'd0, bus.load_l};
  assign load_ok  = (bus.load_l <= bcd_digit_t'(BCD_MAX_DIGIT)) && (load_sum <= 8'(MAX_VAL));
  assign load_rej = bus.load && !bus.clr && !load_ok;

  // A rejected load freezes the prescaler phase for that cycle; clear or an
  // accepted load restarts the period from zero.
  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en && !load_rej),
    .sync_rst (bus.clr || (bus.load && load_ok)),
    .step     (step)
  );

  assign at_max  = (bcd_h_reg == MAX_H) && (bcd_l_reg == MAX_L);
  assign at_zero = (bcd_h_reg == '0) && (bcd_l_reg == '0);

  always_comb begin
    bcd_l_next    = bcd_l_reg;
    bcd_h_next    = bcd_h_reg;
    tick_next     = 1'b0;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (bus.clr) begin
      bcd_l_next = '0;
      bcd_h_next = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        bcd_l_next = bus.load_l;
        bcd_h_next = bus.load_h;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (step) begin
      tick_next = 1'b1;
      if (bus.up) begin
        if (at_max) begin
          bcd_l_next = '0;
          bcd_h_next = '0;
          wrap_next  = 1'b1;
        end else if (bcd_l_reg == bcd_digit_t'(BCD_MAX_DIGIT)) begin
          bcd_l_next = '0;
          bcd_h_next = bcd_h_reg + 4'd1;
        end else begin
          bcd_l_next = bcd_l_reg + 4'd1;
        end
      end else begin
        if (at_zero) begin
          bcd_l_next = MAX_L;
          bcd_h_next = MAX_H;
          wrap_next  = 1'b1;
        end else if (bcd_l_reg == '0) begin
          bcd_l_next = bcd_digit_t'(BCD_MAX_DIGIT);
          bcd_h_next = bcd_h_reg - 4'd1;
        end else begin
          bcd_l_next = bcd_l_reg - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_l_reg    <= '0;
      bcd_h_reg    <= '0;
      tick_reg     <= 1'b0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      bcd_l_reg    <= bcd_l_next;
      bcd_h_reg    <= bcd_h_next;
      tick_reg     <= tick_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
    end
  end

  assign bus.bcd_l    = bcd_l_reg;
  assign bus.bcd_h    = bcd_h_reg;
  assign bus.tick     = tick_reg;
  assign bus.wrap     = wrap_reg;
  assign bus.load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter: two instances (CLK_DIV=4/MAX_VAL=23 and CLK_DIV=1/MAX_VAL=29)
// compared cycle by cycle against an integer-valued reference model.
module tb_bcd_counter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // Reference model state, index 0 = instance a, 1 = instance b
  int   m_div [2];
  int   m_max [2];
  int   m_val [2];
  int   m_ph  [2];
  logic m_tick[2];
  logic m_wrap[2];
  logic m_err [2];

  bcd_counter_if bus_a ();
  bcd_counter_if bus_b ();

  bcd_counter #(.CLK_DIV(4), .MAX_VAL(23)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  bcd_counter #(.CLK_DIV(1), .MAX_VAL(29)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k]  = 0;
      m_ph[k]   = 0;
      m_tick[k] = 1'b0;
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
    end
  endtask

  // Behaviour of one rising edge, expressed on the decimal value and period phase
  task automatic model_edge(input int k, input logic en, input logic up, input logic clr,
                            input logic load, input logic [3:0] ll, input logic [3:0] lh);
    bit stepping;
    stepping  = en && (m_ph[k] == m_div[k] - 1);
    m_tick[k] = 1'b0;
    m_wrap[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (clr) begin
      m_val[k] = 0;
      m_ph[k]  = 0;
    end else if (load) begin
      if (ll <= 9 && (int'(lh) * 10 + int'(ll)) <= m_max[k]) begin
        m_val[k] = int'(lh) * 10 + int'(ll);
        m_ph[k]  = 0;
      end else begin
        m_err[k] = 1'b1;
      end
    end else begin
      if (en) m_ph[k] = (m_ph[k] + 1) % m_div[k];
      if (stepping) begin
        m_tick[k] = 1'b1;
        if (up) begin
          m_wrap[k] = (m_val[k] == m_max[k]);
          m_val[k]  = (m_val[k] + 1) % (m_max[k] + 1);
        end else begin
          m_wrap[k] = (m_val[k] == 0);
          m_val[k]  = (m_val[k] + m_max[k]) % (m_max[k] + 1);
        end
      end
    end
  endtask

  task automatic check_all();
    check("a_ones",  8'(bus_a.bcd_l),    8'(m_val[0] % 10));
    check("a_tens",  8'(bus_a.bcd_h),    8'(m_val[0] / 10));
    check("a_tick",  8'(bus_a.tick),     8'(m_tick[0]));
    check("a_wrap",  8'(bus_a.wrap),     8'(m_wrap[0]));
    check("a_lerr",  8'(bus_a.load_err), 8'(m_err[0]));
    check("b_ones",  8'(bus_b.bcd_l),    8'(m_val[1] % 10));
    check("b_tens",  8'(bus_b.bcd_h),    8'(m_val[1] / 10));
    check("b_tick",  8'(bus_b.tick),     8'(m_tick[1]));
    check("b_wrap",  8'(bus_b.wrap),     8'(m_wrap[1]));
    check("b_lerr",  8'(bus_b.load_err), 8'(m_err[1]));
  endtask

  task automatic step_cycle();
    model_edge(0, bus_a.en, bus_a.up, bus_a.clr, bus_a.load, bus_a.load_l, bus_a.load_h);
    model_edge(1, bus_b.en, bus_b.up, bus_b.clr, bus_b.load, bus_b.load_l, bus_b.load_h);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load_a(input logic [3:0] lh, input logic [3:0] ll);
    bus_a.load   = 1'b1;
    bus_a.load_h = lh;
    bus_a.load_l = ll;
    step_cycle();
    bus_a.load   = 1'b0;
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must drop before any edge
  task automatic reset_pulse();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int tick_count;
    clk   = 1'b0;
    rst_n = 1'b0;
    tests = 0;
    fails = 0;
    m_div[0] = 4;
    m_max[0] = 23;
    m_div[1] = 1;
    m_max[1] = 29;
    {bus_a.en, bus_a.up, bus_a.clr, bus_a.load, bus_a.load_l, bus_a.load_h} = '0;
    {bus_b.en, bus_b.up, bus_b.clr, bus_b.load, bus_b.load_l, bus_b.load_h} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Up count from reset: 24 steps in 96 cycles, wrap 23 -> 00
    bus_a.en = 1'b1;
    bus_a.up = 1'b1;
    tick_count = 0;
    repeat (96) begin
      step_cycle();
      tick_count += int'(bus_a.tick);
    end
    check("a_tick_count_96", 8'(tick_count), 8'd24);
    repeat (10) step_cycle();

    // Clear, then count down: 00 -> 23 with wrap, through the tens borrow
    bus_a.clr = 1'b1;
    step_cycle();
    bus_a.clr = 1'b0;
    bus_a.up  = 1'b0;
    repeat (30) step_cycle();

    // Accepted load 19, rejected 24, rejected ones digit 10
    bus_a.up = 1'b1;
    load_a(4'd1, 4'd9);
    repeat (2) step_cycle();
    load_a(4'd2, 4'd4);
    step_cycle();
    load_a(4'd0, 4'd10);
    repeat (8) step_cycle();

    // clr + valid load on the step edge
    for (int i = 0; i < 8 && m_ph[0] != m_div[0] - 1; i++) step_cycle();
    check("a_phase_at_step", 8'(m_ph[0]), 8'(m_div[0] - 1));
    bus_a.clr = 1'b1;
    load_a(4'd0, 4'd5);
    bus_a.clr = 1'b0;
    repeat (6) step_cycle();

    // Freeze after two prescaler cycles, resume from the frozen phase
    bus_a.clr = 1'b1;
    step_cycle();
    bus_a.clr = 1'b0;
    repeat (2) step_cycle();
    bus_a.en = 1'b0;
    repeat (10) step_cycle();
    bus_a.en = 1'b1;
    repeat (6) step_cycle();

    // Reset at value 17 while its tick is showing
    load_a(4'd1, 4'd6);
    for (int i = 0; i < 10 && !(m_tick[0] && m_val[0] == 17); i++) step_cycle();
    check("a_tick_at_17", 8'(bus_a.tick), 8'd1);
    reset_pulse();
    repeat (9) step_cycle();

    // Instance b: step every cycle, wrap 29 -> 00, then down and a reset
    bus_a.en = 1'b0;
    bus_b.en = 1'b1;
    bus_b.up = 1'b1;
    repeat (35) step_cycle();
    bus_b.up = 1'b0;
    repeat (5) step_cycle();
    reset_pulse();
    repeat (3) step_cycle();

    // Randomised traffic on both instances
    for (int n = 0; n < 400; n++) begin
      bus_a.en     = ($urandom_range(0, 9) != 0);
      bus_a.up     = 1'($urandom_range(0, 1));
      bus_a.clr    = ($urandom_range(0, 29) == 0);
      bus_a.load   = ($urandom_range(0, 14) == 0);
      bus_a.load_l = 4'($urandom_range(0, 11));
      bus_a.load_h = 4'($urandom_range(0, 3));
      bus_b.en     = ($urandom_range(0, 9) != 0);
      bus_b.up     = 1'($urandom_range(0, 1));
      bus_b.clr    = ($urandom_range(0, 29) == 0);
      bus_b.load   = ($urandom_range(0, 14) == 0);
      bus_b.load_l = 4'($urandom_range(0, 11));
      bus_b.load_h = 4'($urandom_range(0, 3));
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
